fwd_hazard_ctrl: RTL and testbench
==================================

# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the pipelined core, generalising the fixed two-port, E/M/W bypass comparison to NRP read ports, DEPTH post-decode stages and per-instruction result latency. It tracks in-flight register writers in an internal shift register of tags. From that state it generates:
- per-port bypass selects for the Execute stage;
- load-use stalls for Fetch and Decode;
- Decode and Execute flushes, with branch flushes taking priority.

It sits beside the datapath. All compare logic lives here; the datapath only supplies addresses and consumes selects.

## Interface
Parameters:
- AW, 4, register address width
- NRP, 2, number of register read ports per instruction
- DEPTH, 3, pipeline stages after Decode (stage 0 = E, 1 = M, …, DEPTH-1 = W); DEPTH ≥ 2
- PC_REG, 15, register address that is never forwarded or stalled on (reads return PC+8)

Derived: SW = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  one clock; reset is asynchronous and active-low (reset = 0 clears all state)
- d_valid  in  1  Decode holds a real instruction
- d_ra  in  NRP*AW  Decode read addresses; port p occupies bits [p*AW +: AW]
- d_ruse  in  NRP  port p is actually read
- d_we  in  1  Decode instruction writes a register
- d_wa  in  AW  Decode destination address
- d_lat  in  SW  first stage index whose output is forwardable (1 = ALU result from M, 2 = load data from W); 0 is treated as 1
- br_taken  in  1  branch resolved taken in E
- stall_f  out  1  hold the PC
- stall_d  out  1  hold the Decode register
- flush_d  out  1  clear the Decode register
- flush_e  out  1  insert a bubble into E
- fwd_sel  out  NRP*SW  per-port E-stage bypass select: 0 = register-file value, k = result of stage k (1..DEPTH-1)
- hz_err  out  1  sticky: E read a register whose youngest writer was not yet forwardable
- perf_stall, perf_flush  out  16 each  present only with HZ_PERF_CNT_EN

## Operation
- Writer table: DEPTH entries of {v, wa, lat}; entry k describes the instruction in stage k.
  - Every cycle, entries 1..DEPTH-1 load from k-1; post-E stages never stall.
  - Entry 0 loads {d_valid & d_we, d_wa, max(d_lat,1)} when Decode advances. Otherwise it loads v = 0.
- E read tags: per port, {use, ra} registered from Decode on advance; use = 0 on a bubble.
- Match rule: a table entry k matches address a when v = 1, wa = a and a ≠ PC_REG.
- Load-use hazard for Decode port p (d_valid & d_ruse[p]):
  - Find the youngest (lowest k) entry matching d_ra[p].
  - Hazard when k + 1 < lat of that entry.
  - Older matches are ignored; the youngest writer shadows them.
- ld_stall = OR of the hazard over all ports.
- Output equations:
  - stall_f = stall_d = ld_stall & ~br_taken
  - flush_d = br_taken
  - flush_e = br_taken | ld_stall
  - Decode advances when ~flush_e.
- fwd_sel[p], for the E instruction:
  - Considers only entries 1..DEPTH-1, youngest match first.
  - Equals k if that youngest match has k ≥ lat; otherwise 0.
  - 0 when use = 0 or there is no match.
- hz_err is set when the youngest match exists with k < lat. It clears only on reset.
- The register file is write-through (W writes are visible to D reads in the same cycle). This block never forwards into Decode.

## Timing
- Reset values:
  - Table and E tags cleared.
  - stall_f, stall_d, flush_d, flush_e = 0 unless br_taken is high; they are combinational from state and inputs.
  - fwd_sel = 0, hz_err = 0, perf counters = 0.
- Outputs are combinational from current state and inputs; the table updates one cycle after an advance.
- Load-use with lat = 2 costs exactly one stall cycle. An ALU dependency (lat = 1) costs zero.
- br_taken together with ld_stall: the flush wins. There is no stall, and both D and E are cleared.
- Reset asserted mid-operation clears the table immediately (asynchronous). The first post-reset cycle has no stalls.

## Configuration
- HZ_PERF_CNT_EN defined:
  - perf_stall increments every cycle stall_d = 1.
  - perf_flush increments every cycle br_taken = 1.
  - Both are 16-bit, saturate at 16'hFFFF and clear on reset.
- Not defined: the perf ports and counters are absent.

## Test plan
All scenarios use the defaults (AW = 4, NRP = 2, DEPTH = 3).
- ALU back-to-back: I0 writes R3 (lat 1), then I1 reads R3 on port 0 → no stall; fwd_sel[0] = 1 while I1 is in E.
- Load-use: LDR R3 (lat 2), then I1 reads R3 → stall_f = stall_d = flush_e = 1 for exactly 1 cycle; next cycle I1 is in E with fwd_sel[0] = 2; hz_err stays 0.
- Shadowing: W-stage writer of R5 (lat 1) and M-stage writer of R5 (lat 1), E reads R5 → fwd_sel = 1.
- PC exclusion: in-flight writer to R15, then a read of R15 → fwd_sel = 0, no stall.
- Priority: load-use stall condition with br_taken = 1 → stall_d = 0, flush_d = 1, flush_e = 1; the table entry 0 is invalid next cycle.
- Reset: pulse reset low mid load-use → all outputs 0 immediately. With HZ_PERF_CNT_EN, after 70000 stall cycles perf_stall = 16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and hazard controller for the pipelined core. It keeps a small
// shift register of in-flight register writers, one entry per post-Decode
// stage (entry 0 = E, entry DEPTH-1 = W). From that state and the Decode
// operands it produces:
//   - per-port E-stage bypass selects,
//   - load-use stalls for Fetch/Decode,
//   - Decode/Execute flushes (a taken branch beats a load-use stall).
//
// Optional feature macro: HZ_PERF_CNT_EN adds saturating 16-bit stall and
// flush event counters (ports perf_stall / perf_flush).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low; clears writer table, E tags, hz_err
//   d_valid    Decode holds a real instruction
//   d_ra       Decode read addresses, port p at [p*AW +: AW]
//   d_ruse     per-port "actually read" flags
//   d_we/d_wa  Decode destination write enable / address
//   d_lat      first stage index whose result is forwardable (0 means 1)
//   br_taken   branch resolved taken in E
//   stall_f    hold the PC
//   stall_d    hold the Decode register
//   flush_d    clear the Decode register
//   flush_e    insert a bubble into E
//   fwd_sel    per-port bypass select (0 = RF, k = result of stage k)
//   hz_err     sticky: E consumed a value that was not yet forwardable
//   perf_stall/perf_flush  event counters (HZ_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
   parameter int AW     = 4,
   parameter int NRP    = 2,
   parameter int DEPTH  = 3,
   parameter int PC_REG = 15,
   localparam int SW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [NRP*AW-1:0] d_ra,
   input  logic [NRP-1:0]    d_ruse,
   input  logic              d_we,
   input  logic [AW-1:0]     d_wa,
   input  logic [SW-1:0]     d_lat,
   input  logic              br_taken,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e,
   output logic [NRP*SW-1:0] fwd_sel,
   output logic              hz_err
`ifdef HZ_PERF_CNT_EN
   ,
   output logic [15:0]       perf_stall,
   output logic [15:0]       perf_flush
`endif
);

   localparam logic [AW-1:0] PC_A = AW'(PC_REG);

   // Writer table, entry k = instruction currently in post-Decode stage k
   logic          tbl_v   [DEPTH];
   logic [AW-1:0] tbl_wa  [DEPTH];
   logic [SW-1:0] tbl_lat [DEPTH];

   // Read tags of the instruction in E (stage 0)
   logic [NRP-1:0] use_p0;
   logic [AW-1:0]  ra_p0 [NRP];

   logic [NRP-1:0] d_found;
   logic [NRP-1:0] port_hz;
   logic [NRP-1:0] e_found;
   logic           ld_stall;
   logic           advance;
   logic           hz_set;

   // A latency of 0 would claim the result exists before E; treat it as 1.
   function automatic logic [SW-1:0] lat_clamp(input logic [SW-1:0] l);
      return (l == '0) ? SW'(1) : l;
   endfunction

   // PC reads are served by the datapath (PC+8), so they never match.
   function automatic logic hit(input logic          v,
                                input logic [AW-1:0] wa,
                                input logic [AW-1:0] a);
      return v && (wa == a) && (a != PC_A);
   endfunction

   // Decode-side load-use detection. Only the youngest matching writer
   // counts; it shadows any older writer of the same register. The Decode
   // instruction would meet writer k one stage further on (k+1) in E.
   always_comb begin
      d_found = '0;
      port_hz = '0;
      for (int p = 0; p < NRP; p++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (!d_found[p] && d_valid && d_ruse[p] &&
                hit(tbl_v[k], tbl_wa[k], d_ra[p*AW +: AW])) begin
               d_found[p] = 1'b1;
               port_hz[p] = (k + 1) < int'(tbl_lat[k]);
            end
         end
      end
   end

   assign ld_stall = |port_hz;
   assign stall_f  = ld_stall & ~br_taken;
   assign stall_d  = ld_stall & ~br_taken;
   assign flush_d  = br_taken;
   assign flush_e  = br_taken | ld_stall;
   assign advance  = ~flush_e;

   // E-stage bypass select. Entry 0 is the E instruction itself, so the
   // search starts at stage 1. A youngest match that is still too early is
   // a control bug upstream and is flagged through hz_err.
   always_comb begin
      e_found = '0;
      fwd_sel = '0;
      hz_set  = 1'b0;
      for (int p = 0; p < NRP; p++) begin
         for (int k = 1; k < DEPTH; k++) begin
            if (!e_found[p] && use_p0[p] &&
                hit(tbl_v[k], tbl_wa[k], ra_p0[p])) begin
               e_found[p] = 1'b1;
               if (k >= int'(tbl_lat[k]))
                  fwd_sel[p*SW +: SW] = SW'(k);
               else
                  hz_set = 1'b1;
            end
         end
      end
   end

   // Stage boundary: Decode -> E (entry 0 / E tags), then E -> M -> ... -> W
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            tbl_v[k]   <= 1'b0;
            tbl_wa[k]  <= '0;
            tbl_lat[k] <= '0;
         end
         use_p0 <= '0;
         for (int p = 0; p < NRP; p++)
            ra_p0[p] <= '0;
         hz_err <= 1'b0;
      end else begin
         // Post-E stages never stall, so the table always shifts.
         for (int k = 1; k < DEPTH; k++) begin
            tbl_v[k]   <= tbl_v[k-1];
            tbl_wa[k]  <= tbl_wa[k-1];
            tbl_lat[k] <= tbl_lat[k-1];
         end
         tbl_v[0] <= advance & d_valid & d_we;
         if (advance) begin
            tbl_wa[0]  <= d_wa;
            tbl_lat[0] <= lat_clamp(d_lat);
         end
         use_p0 <= advance ? (d_ruse & {NRP{d_valid}}) : '0;
         if (advance) begin
            for (int p = 0; p < NRP; p++)
               ra_p0[p] <= d_ra[p*AW +: AW];
         end
         if (hz_set)
            hz_err <= 1'b1;
      end
   end

`ifdef HZ_PERF_CNT_EN
   // Saturating event counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall <= '0;
         perf_flush <= '0;
      end else begin
         if (stall_d && (perf_stall != 16'hFFFF))
            perf_stall <= perf_stall + 16'd1;
         if (br_taken && (perf_flush != 16'hFFFF))
            perf_flush <= perf_flush + 16'd1;
      end
   end
`else
   // Event counters not built in this configuration.
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Directed bench for fwd_hazard_ctrl at default parameters. Each stimulus
// cycle pushes the hand-computed output vector onto a queue; a monitor pops
// and compares on the falling edge.
// Packed expected vector: {stall_f, stall_d, flush_d, flush_e, fwd_sel[3:0], hz_err}
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;
   localparam int AW = 4, NRP = 2, DEPTH = 3, SW = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              d_valid = 1'b0;
   logic [NRP*AW-1:0] d_ra = '0;
   logic [NRP-1:0]    d_ruse = '0;
   logic              d_we = 1'b0;
   logic [AW-1:0]     d_wa = '0;
   logic [SW-1:0]     d_lat = '0;
   logic              br_taken = 1'b0;
   logic              stall_f, stall_d, flush_d, flush_e, hz_err;
   logic [NRP*SW-1:0] fwd_sel;
`ifdef HZ_PERF_CNT_EN
   logic [15:0]       perf_stall, perf_flush;
`endif

   typedef struct {
      string      nm;
      logic [8:0] v;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   logic [8:0] act;
   int n_chk = 0;
   int n_err = 0;
   int exp_stall_cnt = 0;
   int exp_flush_cnt = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.AW(AW), .NRP(NRP), .DEPTH(DEPTH), .PC_REG(15)) dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_ra(d_ra),
      .d_ruse(d_ruse), .d_we(d_we), .d_wa(d_wa), .d_lat(d_lat),
      .br_taken(br_taken), .stall_f(stall_f), .stall_d(stall_d),
      .flush_d(flush_d), .flush_e(flush_e), .fwd_sel(fwd_sel),
      .hz_err(hz_err)
`ifdef HZ_PERF_CNT_EN
      , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
   );

   function automatic logic [8:0] ex(input logic stall, input logic fd,
                                     input logic fe, input logic [1:0] fs1,
                                     input logic [1:0] fs0, input logic he);
      return {stall, stall, fd, fe, fs1, fs0, he};
   endfunction

   // One clock of stimulus: drive 1 time unit after the rising edge and queue
   // the outputs expected for this cycle.
   task automatic step(input string nm, input logic rn, input logic dv,
                       input logic [3:0] r0, input logic [3:0] r1,
                       input logic [1:0] ru, input logic we,
                       input logic [3:0] wa, input logic [1:0] lat,
                       input logic br, input logic [8:0] e);
      exp_t item;
      @(posedge clk);
      #1;
      reset    = rn;
      d_valid  = dv;
      d_ra     = {r1, r0};
      d_ruse   = ru;
      d_we     = we;
      d_wa     = wa;
      d_lat    = lat;
      br_taken = br;
      item.nm  = nm;
      item.v   = e;
      exp_q.push_back(item);
      if (!rn) begin
         exp_stall_cnt = 0;
         exp_flush_cnt = 0;
      end else begin
         if (e[7]) exp_stall_cnt++;
         if (br)   exp_flush_cnt++;
      end
   endtask

   task automatic nop(input string nm, input logic [8:0] e);
      step(nm, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 2'd0, 1'b0, e);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         act = {stall_f, stall_d, flush_d, flush_e, fwd_sel, hz_err};
         n_chk++;
         if (act !== cur.v) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (sf sd fd fe fs1 fs0 he)",
                     cur.nm, act, cur.v);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state, also with a branch present under reset
      step("rst_idle", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      step("rst_br",   0, 0, 0, 0, 2'b00, 0, 0, 0, 1, ex(0,1,1,0,0,0));
      nop("post_rst", ex(0,0,0,0,0,0));

      // ALU back-to-back: no stall, M forward
      step("alu_i0", 1, 1, 0, 0, 2'b00, 1, 3, 1, 0, ex(0,0,0,0,0,0));
      step("alu_i1", 1, 1, 3, 0, 2'b01, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      nop("alu_fwd", ex(0,0,0,0,1,0));
      nop("alu_d1", ex(0,0,0,0,0,0));
      nop("alu_d2", ex(0,0,0,0,0,0));

      // Load-use: one stall cycle, then W forward
      step("ld",      1, 1, 0, 0, 2'b00, 1, 3, 2, 0, ex(0,0,0,0,0,0));
      step("ld_use",  1, 1, 3, 0, 2'b01, 0, 0, 0, 0, ex(1,0,1,0,0,0));
      step("ld_hold", 1, 1, 3, 0, 2'b01, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      nop("ld_fwd", ex(0,0,0,0,2,0));
      nop("ld_d1", ex(0,0,0,0,0,0));

      // Shadowing in E on port 1: M writer wins over W writer
      step("sh_w",   1, 1, 0, 0, 2'b00, 1, 5, 1, 0, ex(0,0,0,0,0,0));
      step("sh_m",   1, 1, 0, 0, 2'b00, 1, 5, 1, 0, ex(0,0,0,0,0,0));
      step("sh_rd",  1, 1, 0, 5, 2'b10, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      nop("sh_fwd", ex(0,0,0,1,0,0));
      nop("sh_d1", ex(0,0,0,0,0,0));

      // PC register is never forwarded or stalled on
      step("pc_wr", 1, 1, 0, 0, 2'b00, 1, 15, 2, 0, ex(0,0,0,0,0,0));
      step("pc_rd", 1, 1, 15, 15, 2'b11, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      nop("pc_e", ex(0,0,0,0,0,0));
      nop("pc_d1", ex(0,0,0,0,0,0));

      // Branch beats load-use; entry 0 is left invalid
      step("pri_ld",   1, 1, 0, 0, 2'b00, 1, 3, 2, 0, ex(0,0,0,0,0,0));
      step("pri_br",   1, 1, 3, 0, 2'b01, 1, 3, 2, 1, ex(0,1,1,0,0,0));
      step("pri_next", 1, 1, 3, 0, 2'b01, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      nop("pri_fwd", ex(0,0,0,0,2,0));
      nop("pri_d1", ex(0,0,0,0,0,0));

      // Asynchronous reset in the middle of a load-use stall
      step("r_ld",   1, 1, 0, 0, 2'b00, 1, 3, 2, 0, ex(0,0,0,0,0,0));
      step("r_use",  1, 1, 3, 0, 2'b01, 0, 0, 0, 0, ex(1,0,1,0,0,0));
      step("r_rst",  0, 1, 3, 0, 2'b01, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      step("r_post", 1, 1, 3, 0, 2'b01, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      nop("r_e", ex(0,0,0,0,0,0));

      // Decode shadowing: young lat-1 writer hides older lat-3 writer
      step("ds_old", 1, 1, 0, 0, 2'b00, 1, 9, 3, 0, ex(0,0,0,0,0,0));
      step("ds_new", 1, 1, 0, 0, 2'b00, 1, 9, 1, 0, ex(0,0,0,0,0,0));
      step("ds_rd",  1, 1, 0, 9, 2'b10, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      nop("ds_fwd", ex(0,0,0,1,0,0));
      nop("ds_d1", ex(0,0,0,0,0,0));

      // Latency 3 writer: two stall cycles, value then comes from the RF
      step("l3_wr",  1, 1, 0, 0, 2'b00, 1, 6, 3, 0, ex(0,0,0,0,0,0));
      step("l3_u0",  1, 1, 6, 0, 2'b01, 0, 0, 0, 0, ex(1,0,1,0,0,0));
      step("l3_u1",  1, 1, 6, 0, 2'b01, 0, 0, 0, 0, ex(1,0,1,0,0,0));
      step("l3_go",  1, 1, 6, 0, 2'b01, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      nop("l3_e", ex(0,0,0,0,0,0));

      // Latency 0 behaves as 1
      step("z_wr", 1, 1, 0, 0, 2'b00, 1, 7, 0, 0, ex(0,0,0,0,0,0));
      step("z_rd", 1, 1, 0, 7, 2'b10, 0, 0, 0, 0, ex(0,0,0,0,0,0));
      nop("z_fwd", ex(0,0,0,1,0,0));
      nop("z_d1", ex(0,0,0,0,0,0));
      nop("z_d2", ex(0,0,0,0,0,0));

      // Let the monitor consume the last entries, bounded
      for (int i = 0; i < 4 && exp_q.size() > 0; i++)
         @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, 0 required", exp_q.size());
      end

`ifdef HZ_PERF_CNT_EN
      @(posedge clk);
      #1;
      n_chk++;
      if (perf_stall !== 16'(exp_stall_cnt)) begin
         n_err++;
         $display("FAIL perf_stall: got %0d expected %0d", perf_stall, exp_stall_cnt);
      end
      n_chk++;
      if (perf_flush !== 16'(exp_flush_cnt)) begin
         n_err++;
         $display("FAIL perf_flush: got %0d expected %0d", perf_flush, exp_flush_cnt);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
